mips_cpu_instr_memory: RTL and testbench
========================================

Name: mips_cpu_instr_memory

Overview:
Responder for the Harvard CPU's instruction-fetch port. It holds the program image in a word array at the reset vector and returns instr_readdata for every instr_address the CPU presents. The array is filled at run time through a word-serial valid/ready load port, so benches and the top level can stream a program instead of hard-coding one. It also tracks a sticky fault flag for fetches that fall outside the image.

Parameters:
BASE_ADDR, 32'hBFC00000, byte address of word 0 (the CPU reset vector)
DEPTH, 64, number of 32-bit instruction words; a power of 2, at least 2
ADDR_W, 6, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
clk_enable  input  1  when 0, all sequential state holds
instr_address  input  32  CPU fetch byte address
instr_readdata  output  32  instruction word returned to the CPU
load_start  input  1  pulse; (re)starts a load at word 0
load_valid  input  1  load_data is valid this cycle
load_data  input  32  instruction word to store
load_last  input  1  qualifies load_data as the final word of the image
load_ready  output  1  block accepts a word this cycle
loaded  output  1  image complete; fetches are served
word_count  output  ADDR_W+1  number of words stored by the current or most recent load
fetch_fault  output  1  sticky: an out-of-image fetch occurred while loaded

Behaviour:
- Reset: when reset==0 at a rising clk edge, regardless of clk_enable:
  - all array words become 0
  - state goes to IDLE
  - word_count=0, loaded=0, fetch_fault=0, load_ready=0
- FSM states: IDLE, LOAD, DONE. load_ready=1 only in LOAD. loaded=1 only in DONE.
- IDLE: load_start moves to LOAD with ptr=0 and word_count=0. All other inputs are ignored.
- LOAD: a transfer occurs when load_valid and load_ready are both 1 at an edge.
  - The transfer writes mem[ptr]=load_data and increments ptr and word_count.
  - Go to DONE when the transfer has load_last=1, or when it writes word DEPTH-1 (word_count=DEPTH).
  - Array contents beyond word_count are not cleared by a new load.
- DONE: load_start returns to LOAD with ptr=0 and word_count=0, and clears fetch_fault. The array is kept.
- load_start in LOAD: restarts at ptr=0. A load_valid word in the same cycle is discarded, with no write and no count.
- clk_enable=0: state, ptr, word_count, the array and fetch_fault all hold. load_ready is forced to 0. The read path stays live.
- Read path (combinational, zero latency, same cycle as instr_address):
  - In-image means: instr_address[1:0]==0 and BASE_ADDR <= instr_address < BASE_ADDR+4*DEPTH. Compute the subtraction in 33 bits so there is no wrap at 0xFFFFFFFC.
  - instr_readdata = mem[(instr_address-BASE_ADDR)>>2] when loaded=1 and the address is in-image.
  - Otherwise instr_readdata=32'h00000000 (NOP). This covers every address while not loaded, out-of-image addresses and misaligned addresses.
- fetch_fault: set at an edge when all of the following hold: loaded=1, clk_enable=1, the address is not in-image, and instr_address != 32'h00000000.
  - Address 0 is the CPU halt target and never faults.
  - Once set, fetch_fault holds until reset or a load_start in DONE.
- Address-0 fetches while loaded always return 0.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then instr_address=BFC00000 -> instr_readdata=0, loaded=0, load_ready=0, word_count=0, fetch_fault=0.
- Basic load and fetch: load_start, then stream 24420001, 00000008, 24420001 (load_last on the 3rd word) -> loaded=1 the cycle after the 3rd transfer, word_count=3. Fetch BFC00004 -> 00000008. Fetch BFC0000C -> 00000000 and fetch_fault stays 0 (in-image, unloaded word).
- Full and backpressure: with DEPTH=64, stream 64 words with no load_last, dropping load_valid for 3 cycles mid-stream -> no writes during the gap, DONE after word 64, word_count=64. BFC000FC returns the 64th word. BFC00100 returns 0 and fetch_fault=1 at the next edge.
- Halt and misaligned: loaded, instr_address=0 for 5 cycles -> data 0 and fetch_fault stays 0. Then BFC00002 -> data 0 and fetch_fault=1. Then load_start -> fetch_fault=0, loaded=0.
- Restart and clk_enable: in LOAD after 2 words, assert load_start together with load_valid (data DEADBEEF) -> word_count=0 and mem[0] not DEADBEEF. With clk_enable=0 and load_valid=1 for 4 cycles -> load_ready=0 and no count change.
- Reset mid-load: reset=0 while in LOAD after 5 words -> next cycle IDLE, word_count=0, and a BFC00000 fetch returns 0 after a later 1-word reload of 0 plus load_last.

Source files
------------

// File: rtl/mips_cpu_instr_memory_if.sv
// Instruction-fetch and program-load bus between the CPU/loader and the
// instruction memory.
interface mips_cpu_instr_memory_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (
    output instr_address, load_start, load_valid, load_data, load_last,
    input  instr_readdata, load_ready
  );
  modport slave (
    input  instr_address, load_start, load_valid, load_data, load_last,
    output instr_readdata, load_ready
  );
endinterface

// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory at the reset vector: run-time loaded over a word-serial
// valid/ready port, zero-latency fetch, sticky fault on out-of-image fetches.
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clk_enable_i,
  mips_cpu_instr_memory_if.slave bus,
  output logic                  loaded_o,
  output logic [ADDR_W:0]       word_count_o,
  output logic                  fetch_fault_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN   = 33'(4 * DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic [31:0]         mem_q [DEPTH];
  logic                we;

  logic [32:0]         off;
  logic                in_img;

  // 33-bit offset: a negative result (bit 32) means below the base, and
  // addresses near the top of the space cannot wrap into the image.
  always_comb begin
    off    = {1'b0, bus.instr_address} - BASE33;
    in_img = (bus.instr_address[1:0] == 2'b00) && !off[32] && (off < SPAN);
  end

  assign bus.instr_readdata = (state_q == DONE && in_img) ? mem_q[off[ADDR_W+1:2]]
                                                           : 32'h0;
  assign bus.load_ready     = (state_q == LOAD) && clk_enable_i;
  assign loaded_o           = (state_q == DONE);
  assign word_count_o       = cnt_q;
  assign fetch_fault_o      = fault_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // A restart wins over a word offered in the same cycle.
        if (bus.load_start) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (bus.load_valid && bus.load_ready) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (bus.load_last || ptr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
        end else if (!in_img && bus.instr_address != 32'h0) begin
          fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (clk_enable_i) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      if (we) mem_q[ptr_q] <= bus.load_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed plus randomized bench for mips_cpu_instr_memory, checked every
// cycle against a transaction-level model of the load/fetch rules.
module tb_mips_cpu_instr_memory;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, ce, start, valid, last;
  logic [31:0] addr, data;
  logic        loaded;
  logic [6:0]  wcnt;
  logic        fault;

  mips_cpu_instr_memory_if bus ();
  assign bus.instr_address = addr;
  assign bus.load_start    = start;
  assign bus.load_valid    = valid;
  assign bus.load_data     = data;
  assign bus.load_last     = last;

  mips_cpu_instr_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(6)) dut (
    .clk_i(clk), .reset_i(rst), .clk_enable_i(ce), .bus(bus.slave),
    .loaded_o(loaded), .word_count_o(wcnt), .fetch_fault_o(fault)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 loading, 2 loaded.
  int          m_phase, m_cnt;
  bit          m_fault;
  logic [31:0] m_mem [DEPTH];
  int          n_chk = 0, n_fail = 0;
  bit          chk_en = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_image(input logic [31:0] a);
    longint la = longint'(a);
    return (a % 4 == 0) && la >= longint'(BASE) && la < longint'(BASE) + 4 * DEPTH;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (m_phase == 2 && in_image(a)) return m_mem[(longint'(a) - longint'(BASE)) / 4];
    return 32'h0;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_fault = 0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else if (ce) begin
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
        if (start) m_cnt = 0;
        else if (valid) begin
          m_mem[m_cnt] = data;
          m_cnt++;
          if (last || m_cnt == DEPTH) m_phase = 2;
        end
      end else begin
        if (start) begin m_phase = 1; m_cnt = 0; m_fault = 0; end
        else if (!in_image(addr) && addr != 32'h0) m_fault = 1;
      end
    end
  endtask

  // Inputs were driven at posedge+1; check combinational view, then clock.
  task automatic cyc();
    #1;
    if (chk_en) begin
      chk("readdata",    bus.instr_readdata, exp_rd(addr));
      chk("load_ready",  32'(bus.load_ready), 32'(m_phase == 1 && ce));
      chk("loaded",      32'(loaded), 32'(m_phase == 2));
      chk("word_count",  32'(wcnt), 32'(m_cnt));
      chk("fetch_fault", 32'(fault), 32'(m_fault));
    end
    @(posedge clk);
    model_edge();
    #1;
    start = 0; valid = 0; last = 0;
  endtask

  task automatic put(input logic [31:0] d, input bit l);
    valid = 1; data = d; last = l; cyc();
  endtask

  task automatic fetch(input logic [31:0] a);
    addr = a; cyc();
  endtask

  initial begin
    rst = 0; ce = 1; start = 0; valid = 0; last = 0; addr = BASE; data = 0;
    m_phase = 0; m_cnt = 0; m_fault = 0;
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1; chk_en = 1;
    fetch(BASE);
    chk("reset_rd", bus.instr_readdata, 32'h0);
    chk("reset_cnt", 32'(wcnt), 32'h0);

    // Basic load and fetch
    start = 1; cyc();
    put(32'h24420001, 0); put(32'h00000008, 0); put(32'h24420001, 1);
    chk("basic_loaded", 32'(loaded), 32'h1);
    chk("basic_cnt", 32'(wcnt), 32'd3);
    fetch(BASE + 4);
    addr = BASE + 4; #1 chk("basic_rd1", bus.instr_readdata, 32'h00000008);
    fetch(BASE + 12); fetch(BASE + 12);

    // Full load with a 3-cycle gap
    start = 1; cyc();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 30) begin cyc(); cyc(); cyc(); end
      put(32'h1000_0000 + i, 0);
    end
    chk("full_cnt", 32'(wcnt), 32'd64);
    addr = BASE + 32'hFC; #1 chk("full_top", bus.instr_readdata, 32'h1000_003F);
    fetch(BASE + 32'hFC); fetch(BASE + 32'h100); fetch(BASE + 32'h100);
    chk("full_fault", 32'(fault), 32'h1);

    // Halt address and misaligned
    start = 1; cyc();
    put(32'hAAAA_0000, 1);
    repeat (5) fetch(32'h0);
    fetch(BASE + 2); fetch(BASE);
    start = 1; cyc();

    // Restart mid-load, then clk_enable low
    put(32'h1111_1111, 0); put(32'h2222_2222, 0);
    start = 1; valid = 1; data = 32'hDEADBEEF; cyc();
    ce = 0; repeat (4) begin valid = 1; data = 32'h5555_5555; cyc(); end
    ce = 1;
    put(32'h3333_3333, 1);
    addr = BASE; #1 chk("restart_mem0", bus.instr_readdata, 32'h3333_3333);
    fetch(BASE);

    // Reset mid-load
    start = 1; cyc();
    for (int i = 0; i < 5; i++) put(32'h7000_0000 + i, 0);
    rst = 0; cyc(); rst = 1;
    start = 1; cyc();
    put(32'h0, 1);
    fetch(BASE); fetch(BASE + 4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      rst   = ($urandom_range(0, 499) != 0);
      ce    = ($urandom_range(0, 9) != 0);
      start = (r < 3);
      valid = ($urandom_range(0, 3) != 0);
      data  = $urandom;
      last  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0:       addr = 32'h0;
        1:       addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
        2:       addr = BASE + 4 * $urandom_range(DEPTH - 2, DEPTH + 1);
        3:       addr = BASE + $urandom_range(0, 4 * DEPTH - 1);
        4:       addr = 32'hFFFF_FFFC;
        default: addr = $urandom;
      endcase
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
